// File: rtl/color_pkg.sv
// Shared types and constants for the colour normalisation path.
// The gamma table is only elaborated when COLOR_GAMMA_EN is defined.
package color_pkg;

   typedef enum logic [1:0] {ACC, AVG, DIV, OUT} state_t;

   localparam int DIV_CYCLES = 24;
   localparam int OUT_W      = 8;

   typedef logic [255:0][OUT_W-1:0] gamma_lut_t;

   // (2m+1)^5 * 255^6: compared against 32*q^11 to round 255*(q/255)^2.2 exactly
   function automatic logic [127:0] gamma_step(input int m);
      logic [127:0] k, s6, r;
      k  = 128'(2 * m + 1);
      s6 = 128'd1;
      for (int i = 0; i < 6; i++) s6 = s6 * 128'd255;
      r = k * k * k * k * k * s6;
      return r;
   endfunction

   function automatic gamma_lut_t gamma_table();
      gamma_lut_t   t;
      logic [127:0] p;
      int           m;
      t = '0;
      m = 0;
      for (int q = 0; q < 256; q++) begin
         p = 128'd32;
         for (int i = 0; i < 11; i++) p = p * 128'(q);
         while (m < 255 && gamma_step(m) <= p) m++;
         t[q] = 8'(m);
      end
      return t;
   endfunction

endpackage

// File: rtl/color_seq_div.sv
// Sequential restoring divider: load on start, DIV_CYCLES iterations, done pulse
// when the quotient is final. Quotient saturates to 8 bits; divide by zero yields 0.
module color_seq_div
   import color_pkg::*;
#(
   parameter int IN_W = 16
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  start,
   input  logic [DIV_CYCLES-1:0] num,
   input  logic [IN_W-1:0]       den,
   output logic                  done,
   output logic [OUT_W-1:0]      q
);

   logic [IN_W-1:0]       rem, den_q, diff;
   logic [DIV_CYCLES-1:0] quo;
   logic [4:0]            cnt;
   logic [IN_W:0]         shifted;

   // remainder always stays below den, so IN_W bits hold it
   always_comb begin
      shifted = {rem, quo[DIV_CYCLES-1]};
      diff    = shifted[IN_W-1:0] - den_q;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rem   <= '0;
         den_q <= '0;
         quo   <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else if (start) begin
         rem   <= '0;
         quo   <= num;
         den_q <= den;
         cnt   <= 5'(DIV_CYCLES);
         done  <= 1'b0;
      end else if (cnt != 5'd0) begin
         if (shifted >= {1'b0, den_q}) begin
            rem <= diff;
            quo <= {quo[DIV_CYCLES-2:0], 1'b1};
         end else begin
            rem <= shifted[IN_W-1:0];
            quo <= {quo[DIV_CYCLES-2:0], 1'b0};
         end
         cnt  <= cnt - 5'd1;
         done <= (cnt == 5'd1);
      end else begin
         done <= 1'b0;
      end
   end

   always_comb begin
      if (den_q == '0)                         q = '0;
      else if (|quo[DIV_CYCLES-1:OUT_W])       q = '1;
      else                                     q = quo[OUT_W-1:0];
   end

endmodule

// File: rtl/color_norm_filter.sv
// Averages 2**AVG_LOG2 RGBC samples and normalises R/G/B to the clear channel.
// Define COLOR_GAMMA_EN to add a gamma-2.2 LUT stage (one extra cycle of latency).
module color_norm_filter
   import color_pkg::*;
#(
   parameter int AVG_LOG2 = 2,
   parameter int IN_W     = 16
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   input  logic            raw_valid,
   input  logic [IN_W-1:0] raw_r,
   input  logic [IN_W-1:0] raw_g,
   input  logic [IN_W-1:0] raw_b,
   input  logic [IN_W-1:0] raw_c,
   output logic            raw_ready,
   output logic [7:0]      data_r,
   output logic [7:0]      data_g,
   output logic [7:0]      data_b,
   output logic            data_valid
);

   localparam int ACC_W = IN_W + AVG_LOG2;

   state_t                state;
   logic [ACC_W-1:0]      acc_r, acc_g, acc_b, acc_c;
   logic [AVG_LOG2-1:0]   cnt;
   logic [IN_W-1:0]       avg_r, avg_g, avg_b, avg_c, avg_sel;
   logic [4:0]            dcnt;
   logic [1:0]            ch;
   logic [OUT_W-1:0]      q0, q1, div_q;
   logic                  div_start, div_done, accept;
   logic [DIV_CYCLES-1:0] num;

`ifdef COLOR_GAMMA_EN
   localparam gamma_lut_t GAMMA = gamma_table();
   logic [OUT_W-1:0] g_r, g_g, g_b;
   logic             g_vld;
`endif

   assign accept    = raw_valid & raw_ready;
   assign div_start = (state == DIV) && (dcnt == 5'd0);

   always_comb begin
      case (ch)
         2'd0:    avg_sel = avg_r;
         2'd1:    avg_sel = avg_g;
         default: avg_sel = avg_b;
      endcase
      num = DIV_CYCLES'(avg_sel) * DIV_CYCLES'(255);
   end

   color_seq_div #(.IN_W(IN_W)) u_div (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .start     (div_start),
      .num       (num),
      .den       (avg_c),
      .done      (div_done),
      .q         (div_q)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ACC;
         raw_ready  <= 1'b1;
         acc_r      <= '0;
         acc_g      <= '0;
         acc_b      <= '0;
         acc_c      <= '0;
         cnt        <= '0;
         avg_r      <= '0;
         avg_g      <= '0;
         avg_b      <= '0;
         avg_c      <= '0;
         dcnt       <= '0;
         ch         <= '0;
         q0         <= '0;
         q1         <= '0;
         data_r     <= '0;
         data_g     <= '0;
         data_b     <= '0;
         data_valid <= 1'b0;
`ifdef COLOR_GAMMA_EN
         g_r        <= '0;
         g_g        <= '0;
         g_b        <= '0;
         g_vld      <= 1'b0;
`endif
      end else begin
         data_valid <= 1'b0;
         // R then G quotients shift through q0/q1; B is taken straight from the divider in OUT
         if (div_done) begin
            q0 <= q1;
            q1 <= div_q;
         end
`ifdef COLOR_GAMMA_EN
         g_vld <= 1'b0;
         if (g_vld) begin
            data_r     <= g_r;
            data_g     <= g_g;
            data_b     <= g_b;
            data_valid <= 1'b1;
         end
`endif
         case (state)
            ACC: if (accept) begin
               acc_r <= acc_r + ACC_W'(raw_r);
               acc_g <= acc_g + ACC_W'(raw_g);
               acc_b <= acc_b + ACC_W'(raw_b);
               acc_c <= acc_c + ACC_W'(raw_c);
               cnt   <= cnt + 1'b1;
               if (&cnt) begin
                  state     <= AVG;
                  raw_ready <= 1'b0;
               end
            end
            AVG: begin
               avg_r <= acc_r[ACC_W-1:AVG_LOG2];
               avg_g <= acc_g[ACC_W-1:AVG_LOG2];
               avg_b <= acc_b[ACC_W-1:AVG_LOG2];
               avg_c <= acc_c[ACC_W-1:AVG_LOG2];
               acc_r <= '0;
               acc_g <= '0;
               acc_b <= '0;
               acc_c <= '0;
               cnt   <= '0;
               ch    <= '0;
               dcnt  <= '0;
               state <= DIV;
            end
            DIV: begin
               if (dcnt == 5'(DIV_CYCLES)) begin
                  dcnt <= '0;
                  if (ch == 2'd2) state <= OUT;
                  else            ch    <= ch + 2'd1;
               end else begin
                  dcnt <= dcnt + 5'd1;
               end
            end
            OUT: begin
`ifdef COLOR_GAMMA_EN
               g_r   <= GAMMA[q0];
               g_g   <= GAMMA[q1];
               g_b   <= GAMMA[div_q];
               g_vld <= 1'b1;
`else
               data_r     <= q0;
               data_g     <= q1;
               data_b     <= div_q;
               data_valid <= 1'b1;
`endif
               state     <= ACC;
               raw_ready <= 1'b1;
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_color_norm_filter.sv
// Randomised and directed checks of color_norm_filter against an arithmetic model.
// Define COLOR_GAMMA_EN together with the RTL to exercise the gamma build.
module tb_color_norm_filter;

`ifdef COLOR_GAMMA_EN
   localparam int LAT = 78;
`else
   localparam int LAT = 77;
`endif
   localparam int RDY_LAT = 77;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        raw_valid;
   logic [15:0] raw_r, raw_g, raw_b, raw_c;
   logic        raw_ready;
   logic [7:0]  data_r, data_g, data_b;
   logic        data_valid;

   int checks = 0;
   int errors = 0;
   int sr[4], sg[4], sb[4], sc[4];

   always #5 sys_clk = ~sys_clk;

   color_norm_filter #(.AVG_LOG2(2), .IN_W(16)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .raw_valid  (raw_valid),
      .raw_r      (raw_r),
      .raw_g      (raw_g),
      .raw_b      (raw_b),
      .raw_c      (raw_c),
      .raw_ready  (raw_ready),
      .data_r     (data_r),
      .data_g     (data_g),
      .data_b     (data_b),
      .data_valid (data_valid)
   );

   // Reference: mean of four samples, scale to 0..255 against the mean clear count.
   function automatic int model_q(int x0, int x1, int x2, int x3, int c0, int c1, int c2, int c3);
      int ax, ac, q;
      ax = (x0 + x1 + x2 + x3) / 4;
      ac = (c0 + c1 + c2 + c3) / 4;
      if (ac == 0) q = 0;
      else q = (ax * 255) / ac;
      if (q > 255) q = 255;
`ifdef COLOR_GAMMA_EN
      q = $rtoi(255.0 * ((real'(q) / 255.0) ** 2.2) + 0.5);
`endif
      return q;
   endfunction

   function automatic int exp_r();
      return model_q(sr[0], sr[1], sr[2], sr[3], sc[0], sc[1], sc[2], sc[3]);
   endfunction
   function automatic int exp_g();
      return model_q(sg[0], sg[1], sg[2], sg[3], sc[0], sc[1], sc[2], sc[3]);
   endfunction
   function automatic int exp_b();
      return model_q(sb[0], sb[1], sb[2], sb[3], sc[0], sc[1], sc[2], sc[3]);
   endfunction

   task automatic set_all(input int r, input int g, input int b, input int c);
      for (int i = 0; i < 4; i++) begin
         sr[i] = r; sg[i] = g; sb[i] = b; sc[i] = c;
      end
   endtask

   task automatic push_sample(input int i, input int gap);
      int w;
      raw_r = 16'(sr[i]); raw_g = 16'(sg[i]); raw_b = 16'(sb[i]); raw_c = 16'(sc[i]);
      raw_valid = 1'b1;
      w = 0;
      while (!raw_ready && w < 300) begin
         @(posedge sys_clk); #1; w++;
      end
      @(posedge sys_clk); #1;
      raw_valid = 1'b0;
      repeat (gap) begin @(posedge sys_clk); #1; end
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge sys_clk); #1; lat++;
      end while (!data_valid && lat < 300);
   endtask

   task automatic run_frame(input int gap, output int lat);
      for (int i = 0; i < 3; i++) push_sample(i, gap);
      push_sample(3, 0);
      wait_valid(lat);
   endtask

   task automatic check_data(input string name);
      checks++;
      if (data_r !== 8'(exp_r()) || data_g !== 8'(exp_g()) || data_b !== 8'(exp_b())) begin
         errors++;
         $display("FAIL %s data got (%0d,%0d,%0d) want (%0d,%0d,%0d)", name,
                  data_r, data_g, data_b, exp_r(), exp_g(), exp_b());
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0; raw_valid = 1'b0;
      raw_r = '0; raw_g = '0; raw_b = '0; raw_c = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      checks++;
      if ({data_r, data_g, data_b} !== 24'd0 || data_valid !== 1'b0 || raw_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset got data=(%0d,%0d,%0d) valid=%b ready=%b want 0,0,0 0 1",
                  data_r, data_g, data_b, data_valid, raw_ready);
      end
      sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;
   endtask

   task automatic test_basic();
      int lat;
      set_all(1000, 500, 0, 1000);
      run_frame(0, lat);
      checks++;
      if (lat !== LAT) begin
         errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT);
      end
      checks++;
      if ({data_r, data_g, data_b} !== {8'(exp_r()), 8'(exp_g()), 8'(exp_b())}) begin
         errors++; $display("FAIL basic_data got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                            data_r, data_g, data_b, exp_r(), exp_g(), exp_b());
      end
`ifndef COLOR_GAMMA_EN
      checks++;
      if ({data_r, data_g, data_b} !== {8'd255, 8'd127, 8'd0}) begin
         errors++; $display("FAIL basic_const got (%0d,%0d,%0d) want (255,127,0)",
                            data_r, data_g, data_b);
      end
`endif
      @(posedge sys_clk); #1;
      checks++;
      if (data_valid !== 1'b0) begin
         errors++; $display("FAIL basic_pulse_width got valid=%b want 0", data_valid);
      end
      check_data("basic_hold");
   endtask

   task automatic test_average();
      int lat;
      set_all(0, 0, 0, 1000);
      sr[0] = 100; sr[1] = 200; sr[2] = 300; sr[3] = 400;
      run_frame(1, lat);
      checks++;
      if (lat !== LAT) begin
         errors++; $display("FAIL avg_latency got %0d want %0d", lat, LAT);
      end
      check_data("average");
`ifndef COLOR_GAMMA_EN
      checks++;
      if (data_r !== 8'd63) begin
         errors++; $display("FAIL avg_const got %0d want 63", data_r);
      end
`endif
   endtask

   task automatic test_sat_zero();
      int lat;
      set_all(2000, 1000, 3000, 1000);
      run_frame(0, lat);
      check_data("saturate");
      set_all(500, 500, 500, 0);
      run_frame(2, lat);
      checks++;
      if (lat !== LAT || {data_r, data_g, data_b} !== 24'd0) begin
         errors++; $display("FAIL zero_clear got lat=%0d data=(%0d,%0d,%0d) want lat=%0d data=(0,0,0)",
                            lat, data_r, data_g, data_b, LAT);
      end
   endtask

   task automatic test_drop();
      int lat, bad, spur;
      set_all(1200, 800, 400, 1600);
      for (int i = 0; i < 3; i++) push_sample(i, 0);
      raw_r = 16'(sr[3]); raw_g = 16'(sg[3]); raw_b = 16'(sb[3]); raw_c = 16'(sc[3]);
      raw_valid = 1'b1;
      @(posedge sys_clk); #1;
      raw_r = 16'hFFFF; raw_g = 16'hFFFF; raw_b = 16'hFFFF; raw_c = 16'd1;
      lat = 0; bad = 0;
      do begin
         @(posedge sys_clk); #1; lat++;
         if (lat < RDY_LAT && raw_ready) bad++;
      end while (!data_valid && lat < 300);
      raw_valid = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL drop_ready got %0d ready cycles want 0", bad);
      end
      checks++;
      if (lat !== LAT) begin
         errors++; $display("FAIL drop_latency got %0d want %0d", lat, LAT);
      end
      check_data("drop_first");
      // the saved expectation stays valid while the next three fresh samples are taken
      set_all(3000, 1500, 750, 3000);
      sr[3] = 1000; sg[3] = 100; sb[3] = 2500; sc[3] = 1000;
      for (int i = 0; i < 3; i++) sr[i] = sr[i];
      spur = 0;
      for (int i = 0; i < 3; i++) begin
         push_sample(i, 0);
         if (data_valid) spur++;
      end
      repeat (100) begin
         @(posedge sys_clk); #1;
         if (data_valid) spur++;
      end
      checks++;
      if (spur !== 0) begin
         errors++; $display("FAIL drop_partial got %0d valid pulses want 0", spur);
      end
      push_sample(3, 0);
      wait_valid(lat);
      checks++;
      if (lat !== LAT) begin
         errors++; $display("FAIL drop_next_latency got %0d want %0d", lat, LAT);
      end
      check_data("drop_next");
   endtask

   task automatic test_reset_mid();
      int lat;
      set_all(900, 300, 600, 1200);
      for (int i = 0; i < 4; i++) push_sample(i, 0);
      repeat (30) begin @(posedge sys_clk); #1; end
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if ({data_r, data_g, data_b} !== 24'd0 || data_valid !== 1'b0 || raw_ready !== 1'b1) begin
         errors++; $display("FAIL reset_mid got data=(%0d,%0d,%0d) valid=%b ready=%b want 0,0,0 0 1",
                            data_r, data_g, data_b, data_valid, raw_ready);
      end
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      set_all(4000, 2000, 1000, 8000);
      run_frame(0, lat);
      checks++;
      if (lat !== LAT) begin
         errors++; $display("FAIL reset_mid_latency got %0d want %0d", lat, LAT);
      end
      check_data("reset_mid_next");
   endtask

   task automatic test_random();
      int lat;
      for (int f = 0; f < 10; f++) begin
         for (int i = 0; i < 4; i++) begin
            sr[i] = int'($urandom_range(0, 65535));
            sg[i] = int'($urandom_range(0, 65535));
            sb[i] = int'($urandom_range(0, 2000));
            sc[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                                : int'($urandom_range(1000, 65535));
         end
         run_frame(int'($urandom_range(0, 2)), lat);
         checks++;
         if (lat !== LAT) begin
            errors++; $display("FAIL random_latency frame %0d got %0d want %0d", f, lat, LAT);
         end
         check_data("random");
      end
   endtask

`ifdef COLOR_GAMMA_EN
   task automatic test_gamma();
      int lat;
      set_all(128, 255, 0, 255);
      run_frame(0, lat);
      checks++;
      if (lat !== 78 || data_r !== 8'd56 || data_g !== 8'd255 || data_b !== 8'd0) begin
         errors++; $display("FAIL gamma got lat=%0d data=(%0d,%0d,%0d) want lat=78 data=(56,255,0)",
                            lat, data_r, data_g, data_b);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_average();
      test_sat_zero();
      test_drop();
      test_reset_mid();
      test_random();
`ifdef COLOR_GAMMA_EN
      test_gamma();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
